// File: rtl/fifo_pixel_streamer_pkg.sv
// Shared constants and types for the pixel FIFO read side and its output streamer.
// The FIFO and the streamer both import these so their geometry and width agree.
package fifo_pixel_streamer_pkg;

  localparam int PIX_WIDTH      = 24;
  localparam int OBUF_DEPTH     = 3;
  localparam int IMG_WIDTH_DEF  = 960;
  localparam int IMG_HEIGHT_DEF = 540;

  typedef logic [PIX_WIDTH-1:0] pixel_t;
  typedef logic [1:0]           obuf_ptr_t;

  // Buffer pointers wrap at the depth (2 -> 0), not at the 2-bit range.
  function automatic obuf_ptr_t obuf_ptr_next(input obuf_ptr_t p);
    return (p == obuf_ptr_t'(OBUF_DEPTH - 1)) ? '0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/stream_obuf.sv
// Three-entry circular buffer that absorbs FIFO read latency in front of the stream.
// Entries and pointers clear on reset so dout reads zero until the first write.
module stream_obuf
  import fifo_pixel_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem [OBUF_DEPTH];
  obuf_ptr_t             wr_ptr;
  obuf_ptr_t             rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OBUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= obuf_ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= obuf_ptr_next(rd_ptr);
      case ({wr, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fifo_pixel_streamer.sv
// Drains the pixel FIFO into a valid/ready pixel stream with line (tlast) and
// frame (tuser) markers derived from raster counters that advance on each pop.
module fifo_pixel_streamer
  import fifo_pixel_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_WIDTH,
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_odata,
  output logic                  fifo_rd,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser
);

  localparam int X_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int Y_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

  logic           inflight;
  logic [1:0]     buf_count;
  logic           pop;
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;

  // Credit rule: a read is only issued when the word it returns is guaranteed a
  // slot, counting the word already in flight. No dependence on m_axis_tready.
  assign fifo_rd = rst_n & ~fifo_empty &
                   (({1'b0, buf_count} + {2'b00, inflight}) < 3'(OBUF_DEPTH));

  // Handshake: a pixel transfers on any cycle with tvalid=1 and tready=1; while
  // tvalid=1 and tready=0 the pixel and its markers are held unchanged.
  assign pop = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= fifo_rd;
  end

  stream_obuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_obuf (
    .clk  (clk),
    .rst_n(rst_n),
    .wr   (inflight),
    .wdata(fifo_odata),
    .pop  (pop),
    .dout (m_axis_tdata),
    .count(buf_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (pop) begin
      if (x_cnt == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  assign m_axis_tvalid = (buf_count != 2'd0);
  assign m_axis_tlast  = m_axis_tvalid & (x_cnt == X_LAST);
  assign m_axis_tuser  = m_axis_tvalid & (x_cnt == '0) & (y_cnt == '0);

endmodule

// File: tb/tb_fifo_pixel_streamer.sv
// Bench for fifo_pixel_streamer: a queue-based FIFO model feeds the DUT and a
// reference stream model predicts pixel order and raster markers from pop index.
module tb_fifo_pixel_streamer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int DW = 24;

  logic          clk;
  logic          rst_n;
  logic          fifo_empty;
  logic [DW-1:0] fifo_odata;
  logic          fifo_rd;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tuser;

  fifo_pixel_streamer #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_odata   (fifo_odata),
    .fifo_rd      (fifo_rd),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO contents and expected output order
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  bit            acc = 0;
  int            pop_idx = 0;
  int            pops = 0;
  int            first_rd = -1, first_v = -1, first_pop = -1, last_pop = -1;
  int            n_last = 0, n_user = 0;
  bit            got_first_user = 0;
  logic          first_user = 1'b0;
  logic [DW-1:0] next_word = 24'h000001;
  bit            rnd_data = 0;
  int            rdcnt;
  int            k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observe one cycle at the falling edge, scoring any transfer against the model.
  task automatic sample();
    acc = fifo_rd && !fifo_empty;
    chk("rd_when_empty", 32'(fifo_rd && fifo_empty), 32'd0);
    if (fifo_rd && first_rd < 0) first_rd = cyc;
    if (m_axis_tvalid && first_v < 0) first_v = cyc;
    if (m_axis_tvalid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'd1, 32'd0);
      end else begin
        chk("tdata", 32'(m_axis_tdata), 32'(exp_q[0]));
        if (m_axis_tready) begin
          chk("tlast", 32'(m_axis_tlast), 32'((pop_idx % W) == W - 1));
          chk("tuser", 32'(m_axis_tuser), 32'((pop_idx % (W * H)) == 0));
          if (m_axis_tlast) n_last++;
          if (m_axis_tuser) n_user++;
          if (!got_first_user) begin
            got_first_user = 1;
            first_user = m_axis_tuser;
          end
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
          void'(exp_q.pop_front());
          pop_idx++;
          pops++;
        end
      end
    end else begin
      chk("tlast_idle", 32'(m_axis_tlast), 32'd0);
      chk("tuser_idle", 32'(m_axis_tuser), 32'd0);
    end
    chk("obuf_overflow", 32'(dut.inflight && (dut.u_obuf.count == 2'd3) &&
                             !(m_axis_tvalid && m_axis_tready)), 32'd0);
  endtask

  // driver: one clock of FIFO model update, new writes and tready, then observe
  task automatic step(input logic rdy, input int npush);
    logic [DW-1:0] w;
    @(posedge clk);
    #1;
    if (acc) fifo_odata = fifo_q.pop_front();
    for (int i = 0; i < npush; i++) begin
      w = rnd_data ? DW'($urandom) : next_word;
      next_word = next_word + 1'b1;
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    fifo_empty    = (fifo_q.size() == 0);
    m_axis_tready = rdy;
    @(negedge clk);
    cyc++;
    sample();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    fifo_empty = (fifo_q.size() == 0);
    @(negedge clk);
    cyc++;
    sample();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_tlast"},  32'(m_axis_tlast),  32'd0);
    chk({tag, "_tuser"},  32'(m_axis_tuser),  32'd0);
    chk({tag, "_tdata"},  32'(m_axis_tdata),  32'd0);
    chk({tag, "_fifo_rd"}, 32'(fifo_rd),      32'd0);
  endtask

  task automatic push_direct(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(next_word);
      exp_q.push_back(next_word);
      next_word = next_word + 1'b1;
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    m_axis_tready = 1'b0;
    fifo_empty    = 1'b1;
    fifo_odata    = '0;
    repeat (3) @(negedge clk);

    // reset state, with the FIFO already holding 0x000001..0x000010
    push_direct(16);
    fifo_empty    = 1'b0;
    m_axis_tready = 1'b1;
    #1;
    check_reset_outputs("reset");
    acc = 0;

    // basic order with tready held high
    release_reset();
    k = 0;
    while (pops < 16 && k < 60) begin
      step(1'b1, 0);
      k++;
    end
    chk("t1_pops", 32'(pops), 32'd16);
    chk("t1_latency", 32'(first_v - first_rd), 32'd2);
    chk("t1_consecutive", 32'(last_pop - first_pop), 32'd15);
    chk("t1_tlast_count", 32'(n_last), 32'd4);
    chk("t1_tuser_count", 32'(n_user), 32'd2);
    chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // backpressure: three reads fill the buffer, then reads stop
    pops  = 0;
    rdcnt = 0;
    step(1'b0, 10);
    if (acc) rdcnt++;
    repeat (7) begin
      step(1'b0, 0);
      if (acc) rdcnt++;
    end
    chk("t2_rd_pulses", 32'(rdcnt), 32'd3);
    chk("t2_rd_stopped", 32'(fifo_rd), 32'd0);
    chk("t2_tvalid_held", 32'(m_axis_tvalid), 32'd1);
    k = 0;
    while (pops < 10 && k < 40) begin
      step(1'b1, 0);
      k++;
    end
    chk("t2_pops", 32'(pops), 32'd10);
    chk("t2_drained", 32'(exp_q.size()), 32'd0);

    // FIFO drains mid-line under random tready, then data returns
    step(1'($urandom_range(0, 1)), 5);
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      step(1'($urandom_range(0, 1)), 0);
      k++;
    end
    chk("t4_drain1", 32'(exp_q.size()), 32'd0);
    repeat (3) step(1'($urandom_range(0, 1)), 0);
    chk("t4_tvalid_low", 32'(m_axis_tvalid), 32'd0);
    chk("t4_rd_low", 32'(fifo_rd), 32'd0);
    step(1'($urandom_range(0, 1)), 9);
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      step(1'($urandom_range(0, 1)), 0);
      k++;
    end
    chk("t4_drain2", 32'(exp_q.size()), 32'd0);

    // reset while two words are buffered and one is in flight
    step(1'b0, 10);
    k = 0;
    while (!((dut.u_obuf.count == 2'd2) && dut.inflight) && k < 10) begin
      step(1'b0, 0);
      k++;
    end
    chk("t5_reached", 32'((dut.u_obuf.count == 2'd2) && dut.inflight), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_reset");
    fifo_q.delete();
    exp_q.delete();
    fifo_empty     = 1'b1;
    acc            = 0;
    pop_idx        = 0;
    got_first_user = 0;
    repeat (2) @(negedge clk);
    release_reset();
    step(1'b1, 8);
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      step(1'b1, 0);
      k++;
    end
    chk("t5_first_tuser_seen", 32'(got_first_user), 32'd1);
    chk("t5_first_tuser", 32'(first_user), 32'd1);
    chk("t5_drained", 32'(exp_q.size()), 32'd0);

    // random stress
    rnd_data = 1;
    n_last   = 0;
    n_user   = 0;
    pops     = 0;
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : 0);
    end
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      step(1'b1, 0);
      k++;
    end
    chk("t6_drained", 32'(exp_q.size()), 32'd0);
    chk("t6_pixels_nonzero", 32'(pops > 100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
